// File: rtl/exe_pkg.sv
// Shared types and defaults for the multithreaded execute stage.
// EXE_MULH_EN enables the signed high-word multiply (op 9).
package exe_pkg;

  localparam int unsigned XLEN_D = 32;
  localparam int unsigned NTRD_D = 8;
  localparam int unsigned NREG_D = 32;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSlt  = 4'd5,
    AluSll  = 4'd6,
    AluSrl  = 4'd7,
    AluMul  = 4'd8,
    AluMulh = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } mul_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef EXE_MULH_EN
    return (op == AluMul) || (op == AluMulh);
`else
    return op == AluMul;
`endif
  endfunction

endpackage

// File: rtl/exe_mt_if.sv
// Bundle of EXE-stage inputs, WB feedback and the registered EXE->MEM outputs.
// slave is the execute stage; master is whatever drives it.
interface exe_mt_if import exe_pkg::*; #(
  parameter int unsigned XLEN = XLEN_D,
  parameter int unsigned NTRD = NTRD_D,
  parameter int unsigned NREG = NREG_D
);
  localparam int unsigned TW = $clog2(NTRD);
  localparam int unsigned RW = $clog2(NREG);

  logic [31:0]     ins_exe;
  logic [XLEN-1:0] data_a_exe;
  logic [XLEN-1:0] data_b_exe;
  logic [15:0]     imm_exe;
  logic [3:0]      alu_op_exe;
  logic            i_type_exe;
  logic [RW-1:0]   reg_rd_a_exe;
  logic [RW-1:0]   reg_rd_b_exe;
  logic [RW-1:0]   reg_wr_exe;
  logic            wr_en_exe;
  logic            wb_sel_exe;
  logic [TW-1:0]   trd_exe;
  logic            flush_exe;
  logic            stall_in;
  logic [TW-1:0]   trd_wb;
  logic [RW-1:0]   reg_wr_wb;
  logic [XLEN-1:0] wb_data_wb;
  logic            wr_en_wb;

  logic [31:0]     ins_mem;
  logic [XLEN-1:0] alu_out_mem;
  logic [XLEN-1:0] st_data_mem;
  logic [TW-1:0]   trd_mem;
  logic [RW-1:0]   reg_wr_mem;
  logic            wr_en_mem;
  logic            wb_sel_mem;
  logic            stall_exe;
  logic            mul_busy;
  logic            of_exe;

  modport slave (
    input  ins_exe, data_a_exe, data_b_exe, imm_exe, alu_op_exe, i_type_exe,
           reg_rd_a_exe, reg_rd_b_exe, reg_wr_exe, wr_en_exe, wb_sel_exe, trd_exe,
           flush_exe, stall_in, trd_wb, reg_wr_wb, wb_data_wb, wr_en_wb,
    output ins_mem, alu_out_mem, st_data_mem, trd_mem, reg_wr_mem, wr_en_mem, wb_sel_mem,
           stall_exe, mul_busy, of_exe
  );

  modport master (
    output ins_exe, data_a_exe, data_b_exe, imm_exe, alu_op_exe, i_type_exe,
           reg_rd_a_exe, reg_rd_b_exe, reg_wr_exe, wr_en_exe, wb_sel_exe, trd_exe,
           flush_exe, stall_in, trd_wb, reg_wr_wb, wb_data_wb, wr_en_wb,
    input  ins_mem, alu_out_mem, st_data_mem, trd_mem, reg_wr_mem, wr_en_mem, wb_sel_mem,
           stall_exe, mul_busy, of_exe
  );

endinterface

// File: rtl/exe_mul_iter.sv
// Iterative sign-magnitude shift-add multiplier: one partial product per cycle.
// EXE_MULH_EN widens the accumulator to 2*XLEN so the high word is available.
module exe_mul_iter import exe_pkg::*; #(
  parameter int unsigned XLEN = XLEN_D
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic            hold,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            is_high,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
`ifdef EXE_MULH_EN
  localparam int unsigned AW = 2 * XLEN;
`else
  localparam int unsigned AW = XLEN;
`endif
  localparam int unsigned CW = $clog2(XLEN);

  mul_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic            sign_q;
  logic            high_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [AW-1:0]   prod;

  assign mag_a = a[XLEN-1] ? -a : a;
  assign mag_b = b[XLEN-1] ? -b : b;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      high_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StBusy;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= AW'(mag_a);
            mplier_q <= mag_b;
            sign_q   <= a[XLEN-1] ^ b[XLEN-1];
            high_q   <= is_high;
          end
        end
        StBusy: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          if (!hold) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Magnitude product is re-signed only when it is presented.
  assign prod = sign_q ? -acc_q : acc_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef EXE_MULH_EN
  assign result = high_q ? prod[AW-1:XLEN] : prod[XLEN-1:0];
`else
  logic unused_high;
  assign unused_high = high_q;
  assign result = prod[XLEN-1:0];
`endif

endmodule

// File: rtl/exe_mt.sv
// Multithreaded execute stage: MEM/WB forwarding, load-use stall, ALU, iterative
// multiplier and the EXE->MEM register. EXE_MULH_EN enables op 9 (MULH).
module exe_mt import exe_pkg::*; #(
  parameter int unsigned XLEN = XLEN_D,
  parameter int unsigned NTRD = NTRD_D,
  parameter int unsigned NREG = NREG_D
) (
  input logic      clk,
  input logic      rst,
  exe_mt_if.slave  bus
);
  localparam int unsigned TW = $clog2(NTRD);
  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned SW = $clog2(XLEN);

  logic [31:0]     ins_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] st_q;
  logic [TW-1:0]   trd_q;
  logic [RW-1:0]   rd_q;
  logic            wr_en_q;
  logic            wb_sel_q;

  logic            mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic            load_use;
  logic [XLEN-1:0] fwd_a, fwd_b, op_b;
  logic [XLEN-1:0] sum, diff, alu_res;
  logic            of;
  logic            mul_start, mul_busy, mul_done, stall;
  logic [XLEN-1:0] mul_res;

  assign mem_hit_a = wr_en_q && (trd_q == bus.trd_exe) && (rd_q == bus.reg_rd_a_exe)
                     && (bus.reg_rd_a_exe != '0);
  assign mem_hit_b = wr_en_q && (trd_q == bus.trd_exe) && (rd_q == bus.reg_rd_b_exe)
                     && (bus.reg_rd_b_exe != '0);
  assign wb_hit_a  = bus.wr_en_wb && (bus.trd_wb == bus.trd_exe)
                     && (bus.reg_wr_wb == bus.reg_rd_a_exe) && (bus.reg_rd_a_exe != '0);
  assign wb_hit_b  = bus.wr_en_wb && (bus.trd_wb == bus.trd_exe)
                     && (bus.reg_wr_wb == bus.reg_rd_b_exe) && (bus.reg_rd_b_exe != '0);
  // A load in MEM has no data yet; its hit blocks the WB path and forces a stall.
  assign load_use  = wb_sel_q && (mem_hit_a || mem_hit_b);

  always_comb begin
    fwd_a = bus.data_a_exe;
    fwd_b = bus.data_b_exe;
    if (mem_hit_a) begin
      if (!wb_sel_q) fwd_a = alu_q;
    end else if (wb_hit_a) begin
      fwd_a = bus.wb_data_wb;
    end
    if (mem_hit_b) begin
      if (!wb_sel_q) fwd_b = alu_q;
    end else if (wb_hit_b) begin
      fwd_b = bus.wb_data_wb;
    end
  end

  assign op_b = bus.i_type_exe ? XLEN'($signed(bus.imm_exe)) : fwd_b;
  assign sum  = fwd_a + op_b;
  assign diff = fwd_a - op_b;

  always_comb begin
    alu_res = '0;
    of      = 1'b0;
    case (bus.alu_op_exe)
      AluAdd: begin
        alu_res = sum;
        of      = (fwd_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != fwd_a[XLEN-1]);
      end
      AluSub: begin
        alu_res = diff;
        of      = (fwd_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != fwd_a[XLEN-1]);
      end
      AluAnd:  alu_res = fwd_a & op_b;
      AluOr:   alu_res = fwd_a | op_b;
      AluXor:  alu_res = fwd_a ^ op_b;
      AluSlt:  alu_res = {{(XLEN - 1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
      AluSll:  alu_res = fwd_a << op_b[SW-1:0];
      AluSrl:  alu_res = fwd_a >> op_b[SW-1:0];
      default: alu_res = '0;
    endcase
  end

  assign mul_start = is_mul_op(bus.alu_op_exe) && !mul_busy && !load_use
                     && !bus.flush_exe && !bus.stall_in;
  assign stall     = load_use || mul_start || (mul_busy && !mul_done);

  exe_mul_iter #(
    .XLEN (XLEN)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .flush   (bus.flush_exe),
    .hold    (bus.stall_in),
    .a       (fwd_a),
    .b       (op_b),
    .is_high (bus.alu_op_exe == AluMulh),
    .busy    (mul_busy),
    .done    (mul_done),
    .result  (mul_res)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.flush_exe || bus.stall_in || stall) begin
      ins_q    <= '0;
      alu_q    <= '0;
      st_q     <= '0;
      trd_q    <= '0;
      rd_q     <= '0;
      wr_en_q  <= 1'b0;
      wb_sel_q <= 1'b0;
    end else begin
      ins_q    <= bus.ins_exe;
      alu_q    <= mul_done ? mul_res : alu_res;
      st_q     <= fwd_b;
      trd_q    <= bus.trd_exe;
      rd_q     <= bus.reg_wr_exe;
      wr_en_q  <= bus.wr_en_exe;
      wb_sel_q <= bus.wb_sel_exe;
    end
  end

  assign bus.ins_mem     = ins_q;
  assign bus.alu_out_mem = alu_q;
  assign bus.st_data_mem = st_q;
  assign bus.trd_mem     = trd_q;
  assign bus.reg_wr_mem  = rd_q;
  assign bus.wr_en_mem   = wr_en_q;
  assign bus.wb_sel_mem  = wb_sel_q;
  assign bus.stall_exe   = stall;
  assign bus.mul_busy    = mul_busy;
  assign bus.of_exe      = of;

endmodule

// File: tb/tb_exe_mt.sv
// Scoreboard bench for exe_mt: issued instructions push expected MEM contents,
// a negedge monitor pops and compares whenever a non-bubble reaches MEM.
module tb_exe_mt;
  import exe_pkg::*;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] alu;
    logic [31:0] st;
    logic [2:0]  trd;
    logic [4:0]  rd;
    logic        we;
    logic        wbsel;
  } resp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        of;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst;
  int    checks = 0;
  int    errors = 0;
  resp_t exp_q[$];

  exe_mt_if #(.XLEN(32), .NTRD(8), .NREG(32)) bus ();

  exe_mt #(.XLEN(32), .NTRD(8), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    resp_t act, e;
    if (!rst && bus.ins_mem != 32'h0) begin
      act = '{bus.ins_mem, bus.alu_out_mem, bus.st_data_mem, bus.trd_mem, bus.reg_wr_mem,
              bus.wr_en_mem, bus.wb_sel_mem};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mem_unexpected: got ins %0h alu %0h, expected no output", act.ins,
                 act.alu);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL mem_out ins %0h: got alu %0h st %0h trd %0d rd %0d we %0b ld %0b (ins %0h), expected alu %0h st %0h trd %0d rd %0d we %0b ld %0b",
                   e.ins, act.alu, act.st, act.trd, act.rd, act.we, act.wbsel, act.ins,
                   e.alu, e.st, e.trd, e.rd, e.we, e.wbsel);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic [31:0] ins, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] trd, input logic [4:0] rda,
                         input logic [4:0] rdb, input logic [4:0] rd, input logic we,
                         input logic wbsel);
    bus.ins_exe      = ins;
    bus.alu_op_exe   = op;
    bus.data_a_exe   = a;
    bus.data_b_exe   = b;
    bus.trd_exe      = trd;
    bus.reg_rd_a_exe = rda;
    bus.reg_rd_b_exe = rdb;
    bus.reg_wr_exe   = rd;
    bus.wr_en_exe    = we;
    bus.wb_sel_exe   = wbsel;
    bus.i_type_exe   = 1'b0;
    bus.imm_exe      = 16'h0;
  endtask

  task automatic idle_in();
    set_ins(32'h0, 4'd0, 32'h0, 32'h0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic set_wb(input logic [2:0] trd, input logic [4:0] rd, input logic [31:0] d,
                        input logic we);
    bus.trd_wb     = trd;
    bus.reg_wr_wb  = rd;
    bus.wb_data_wb = d;
    bus.wr_en_wb   = we;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] st,
                      input logic [2:0] trd, input logic [4:0] rd, input logic we,
                      input logic wbsel);
    exp_q.push_back('{ins, alu, st, trd, rd, we, wbsel});
  endtask

  // Issue at cycle 0; stall for XLEN+1 cycles, DONE (optionally held), then capture.
  task automatic mul_run(input logic [31:0] ins, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int hold);
    set_ins(ins, op, a, b, 3'd0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    push(ins, exp, b, 3'd0, 5'd3, 1'b1, 1'b0);
    #1 check("mul_idle_at_issue", 64'(bus.mul_busy), 64'd0);
    for (int c = 0; c <= int'(XLEN); c++) begin
      #1 check("mul_stall", 64'(bus.stall_exe), 64'd1);
      tick();
    end
    if (hold > 0) begin
      bus.stall_in = 1'b1;
      for (int h = 0; h < hold; h++) begin
        #1 check("mul_done_hold_busy", 64'(bus.mul_busy), 64'd1);
        check("mul_done_hold_bubble", 64'(bus.wr_en_mem), 64'd0);
        tick();
      end
      bus.stall_in = 1'b0;
    end
    #1 check("mul_done_stall", 64'(bus.stall_exe), 64'd0);
    check("mul_done_busy", 64'(bus.mul_busy), 64'd1);
    tick();
    idle_in();
  endtask

  vec_t vecs[15];
  int   wr_seen;

  initial begin
    vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
    vecs[1]  = '{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
    vecs[2]  = '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vecs[3]  = '{4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0};
    vecs[4]  = '{4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
    vecs[5]  = '{4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0};
    vecs[6]  = '{4'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[7]  = '{4'd5,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[8]  = '{4'd6,  32'h00000001, 32'h00000024, 32'h00000010, 1'b0};
    vecs[9]  = '{4'd7,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0};
    vecs[10] = '{4'd12, 32'h00001234, 32'h00005678, 32'h00000000, 1'b0};
    vecs[11] = '{4'd0,  32'h00000003, 32'h00000004, 32'h00000007, 1'b0};
    vecs[12] = '{4'd15, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[13] = '{4'd1,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[14] = '{4'd0,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1};

    rst = 1'b1;
    idle_in();
    set_wb(3'd0, 5'd0, 32'h0, 1'b0);
    bus.flush_exe = 1'b0;
    bus.stall_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_ins_mem", 64'(bus.ins_mem), 64'd0);
    check("reset_alu_out_mem", 64'(bus.alu_out_mem), 64'd0);
    check("reset_wr_en_mem", 64'(bus.wr_en_mem), 64'd0);
    check("reset_mul_busy", 64'(bus.mul_busy), 64'd0);
    check("reset_stall_exe", 64'(bus.stall_exe), 64'd0);

    // Forwarding: MEM beats WB, WB fallback, other thread, forwarded B as store data.
    set_ins(32'h100, 4'd0, 32'h10, 32'h0, 3'd3, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    push(32'h100, 32'h10, 32'h0, 3'd3, 5'd5, 1'b1, 1'b0);
    tick();
    set_wb(3'd3, 5'd5, 32'h20, 1'b1);
    set_ins(32'h101, 4'd0, 32'hDEAD, 32'h0, 3'd3, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
    push(32'h101, 32'h10, 32'h0, 3'd3, 5'd6, 1'b1, 1'b0);
    #1 check("fwd_mem_no_stall", 64'(bus.stall_exe), 64'd0);
    tick();
    set_ins(32'h102, 4'd0, 32'hDEAD, 32'h0, 3'd3, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    push(32'h102, 32'h20, 32'h0, 3'd3, 5'd0, 1'b0, 1'b0);
    tick();
    set_ins(32'h103, 4'd0, 32'h55, 32'h0, 3'd2, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    push(32'h103, 32'h55, 32'h0, 3'd2, 5'd0, 1'b0, 1'b0);
    tick();
    set_ins(32'h104, 4'd0, 32'h1, 32'hBEEF, 3'd3, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
    push(32'h104, 32'h21, 32'h20, 3'd3, 5'd0, 1'b0, 1'b0);
    tick();
    set_wb(3'd0, 5'd0, 32'h0, 1'b0);
    set_ins(32'h105, 4'd0, 32'h1000, 32'hABCD, 3'd0, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0);
    bus.i_type_exe = 1'b1;
    bus.imm_exe    = 16'hFFFC;
    push(32'h105, 32'h00000FFC, 32'hABCD, 3'd0, 5'd0, 1'b0, 1'b0);
    tick();

    foreach (vecs[i]) begin
      set_ins(32'h500 + 32'(i), vecs[i].op, vecs[i].a, vecs[i].b, 3'd0, 5'd0, 5'd0, 5'd1,
              1'b1, 1'b0);
      push(32'h500 + 32'(i), vecs[i].res, vecs[i].b, 3'd0, 5'd1, 1'b1, 1'b0);
      #1 check($sformatf("of_exe_vec%0d", i), 64'(bus.of_exe), 64'(vecs[i].of));
      tick();
    end

    // Load-use: same thread stalls and bubbles; other thread and r0 do not.
    set_ins(32'h200, 4'd0, 32'h40, 32'h0, 3'd1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
    push(32'h200, 32'h40, 32'h0, 3'd1, 5'd7, 1'b1, 1'b1);
    tick();
    set_ins(32'h201, 4'd0, 32'h11, 32'h0, 3'd1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
    #1 check("load_use_stall", 64'(bus.stall_exe), 64'd1);
    tick();
    check("load_use_bubble", 64'(bus.ins_mem), 64'd0);
    set_wb(3'd1, 5'd7, 32'h77, 1'b1);
    push(32'h201, 32'h77, 32'h0, 3'd1, 5'd8, 1'b1, 1'b0);
    #1 check("load_use_release", 64'(bus.stall_exe), 64'd0);
    tick();
    set_wb(3'd0, 5'd0, 32'h0, 1'b0);
    set_ins(32'h202, 4'd0, 32'h40, 32'h0, 3'd1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
    push(32'h202, 32'h40, 32'h0, 3'd1, 5'd7, 1'b1, 1'b1);
    tick();
    set_ins(32'h203, 4'd0, 32'h33, 32'h0, 3'd2, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
    push(32'h203, 32'h33, 32'h0, 3'd2, 5'd0, 1'b0, 1'b0);
    #1 check("load_use_other_thread", 64'(bus.stall_exe), 64'd0);
    tick();
    set_ins(32'h204, 4'd0, 32'h5, 32'h0, 3'd1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    push(32'h204, 32'h5, 32'h0, 3'd1, 5'd0, 1'b1, 1'b1);
    tick();
    set_ins(32'h205, 4'd0, 32'h9, 32'h0, 3'd1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
    push(32'h205, 32'h9, 32'h0, 3'd1, 5'd2, 1'b1, 1'b0);
    #1 check("load_use_r0", 64'(bus.stall_exe), 64'd0);
    tick();

    // stall_in alone, then flush together with stall_in.
    set_ins(32'h600, 4'd0, 32'h1, 32'h2, 3'd0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
    bus.stall_in = 1'b1;
    tick();
    check("stall_in_bubble", 64'(bus.ins_mem), 64'd0);
    bus.stall_in = 1'b0;
    push(32'h600, 32'h3, 32'h2, 3'd0, 5'd4, 1'b1, 1'b0);
    tick();
    set_ins(32'h601, 4'd0, 32'h1, 32'h2, 3'd0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
    bus.flush_exe = 1'b1;
    bus.stall_in  = 1'b1;
    tick();
    check("flush_stall_bubble", 64'(bus.wr_en_mem), 64'd0);
    bus.flush_exe = 1'b0;
    bus.stall_in  = 1'b0;
    idle_in();
    tick();

    mul_run(32'h300, 4'd8, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 0);
    mul_run(32'h301, 4'd8, 32'h00010001, 32'h00010001, 32'h00020001, 0);
    mul_run(32'h302, 4'd8, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h0000001E, 2);
`ifdef EXE_MULH_EN
    mul_run(32'h303, 4'd9, 32'h80000000, 32'h2, 32'hFFFFFFFF, 0);
    mul_run(32'h304, 4'd9, 32'h00010001, 32'h00010001, 32'h00000001, 0);
`else
    set_ins(32'h303, 4'd9, 32'h80000000, 32'h2, 3'd0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    push(32'h303, 32'h0, 32'h2, 3'd0, 5'd3, 1'b1, 1'b0);
    #1 check("mulh_off_no_stall", 64'(bus.stall_exe), 64'd0);
    tick();
    idle_in();
    check("mulh_off_idle", 64'(bus.mul_busy), 64'd0);
    tick();
`endif

    // flush in BUSY cycle 10 discards the multiply.
    set_ins(32'h400, 4'd8, 32'h6, 32'h7, 3'd0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    repeat (10) tick();
    bus.flush_exe = 1'b1;
    tick();
    bus.flush_exe = 1'b0;
    idle_in();
    check("flush_fsm_idle", 64'(bus.mul_busy), 64'd0);
    wr_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.wr_en_mem) wr_seen++;
      tick();
    end
    check("flush_no_write", 64'(wr_seen), 64'd0);

    // rst in BUSY behaves the same.
    set_ins(32'h401, 4'd8, 32'h6, 32'h7, 3'd0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    repeat (6) tick();
    rst = 1'b1;
    idle_in();
    tick();
    rst = 1'b0;
    check("rst_fsm_idle", 64'(bus.mul_busy), 64'd0);
    wr_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.wr_en_mem) wr_seen++;
      tick();
    end
    check("rst_no_write", 64'(wr_seen), 64'd0);

    repeat (3) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/exe_mt.md
Name: exe_mt

Overview:
- Parametrised next-generation execute stage for the multithreaded pipeline.
- Generalises data width, thread count and register count.
- Performs operand forwarding from MEM and WB with load-use stall detection, a single-cycle ALU, and an iterative multi-cycle multiplier (MUL/MULH) driven by an FSM that stalls the front end.
- Sits between the decode/EXE pipeline register and the MEM stage, and owns the EXE→MEM pipeline register.

Parameters:
XLEN, 32, datapath width (≥8, power of 2)
NTRD, 8, hardware thread count; TW = $clog2(NTRD)
NREG, 32, registers per thread; RW = $clog2(NREG)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ins_exe  in  32  instruction word
data_a_exe, data_b_exe  in  XLEN  register-file operands
imm_exe  in  16  immediate, sign-extended to XLEN
alu_op_exe  in  4  operation code (exe_pkg::alu_op_e)
i_type_exe  in  1  B operand = immediate
reg_rd_a_exe, reg_rd_b_exe  in  RW  source registers
reg_wr_exe  in  RW  destination register
wr_en_exe  in  1  writes register
wb_sel_exe  in  1  load instruction
trd_exe  in  TW  thread id
flush_exe  in  1  squash EXE
stall_in  in  1  global hazard-unit stall
trd_wb  in  TW  WB thread id
reg_wr_wb  in  RW  WB destination register
wb_data_wb  in  XLEN  WB data
wr_en_wb  in  1  WB write enable
ins_mem  out  32  registered instruction
alu_out_mem  out  XLEN  registered result / address
st_data_mem  out  XLEN  registered forwarded B (store data)
trd_mem  out  TW  registered thread id
reg_wr_mem  out  RW  registered destination register
wr_en_mem  out  1  registered write enable
wb_sel_mem  out  1  registered load flag
stall_exe  out  1  combinational: hold IF/ID/EXE
mul_busy  out  1  multiplier not IDLE
of_exe  out  1  combinational signed ADD/SUB overflow

Behaviour:
- Reset: all *_mem outputs 0; FSM in IDLE; multiplier counter and accumulator 0.
- Forwarding, per operand:
  - A MEM hit requires trd_mem==trd_exe, wr_en_mem, reg_wr_mem==rd, and rd≠0.
  - MEM hit with wb_sel_mem → stall_exe=1 (load-use); the operand is not forwarded.
  - MEM hit without wb_sel_mem → operand = alu_out_mem.
  - Otherwise a WB hit (same conditions on WB signals) → operand = wb_data_wb.
  - Otherwise the register-file value is used. MEM has priority over WB.
- B operand selection: i_type_exe ? sext(imm_exe) : forwarded B.
- ALU ops:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed, result 1/0).
  - 6 SLL, 7 SRL; shift amount = B[$clog2(XLEN)-1:0].
  - 8 MUL (low XLEN bits), 9 MULH (signed×signed high XLEN bits).
  - Codes 10–15 produce result 0.
- of_exe: signed overflow for ADD/SUB only, 0 for all other ops.
- Multiplier FSM (states IDLE, BUSY, DONE):
  - IDLE→BUSY: on op 8/9 with no load-use stall, !flush_exe and !stall_in. On entry, latch the operand magnitudes and the sign XOR, and clear the counter. stall_exe=1 during this cycle.
  - BUSY: one shift-add step per cycle, XLEN cycles total, with stall_exe=1. After the last step (counter==XLEN-1), go to DONE.
  - DONE: negate the 2·XLEN product if the sign XOR is set. stall_exe=0, so the EXE→MEM register captures the product this cycle. Transition to IDLE if !stall_in; hold DONE while stall_in=1.
  - Latency: op presented at cycle t → result in alu_out_mem at edge t+XLEN+2.
- flush_exe in any state → IDLE next cycle; the partial result is discarded and no write is issued.
- rst mid-multiply → IDLE, nothing written.
- EXE→MEM register:
  - If rst | flush_exe | stall_in | stall_exe → load a bubble (all outputs 0).
  - Otherwise capture the EXE values; alu_out_mem takes the product when in DONE, else the ALU result.
- A flush_exe and stall_in asserted in the same cycle is a single bubble; flush wins.

Optional Feature:
- Macro: EXE_MULH_EN.
- Defined: op 9 returns the signed high word as above; the accumulator is 2·XLEN wide.
- Undefined: op 9 is treated as undefined (result 0, no FSM start); the accumulator is XLEN wide, and MUL returns the low word only.

Decomposition:
- exe_pkg: alu_op_e enum (4-bit); mul_state_e {IDLE, BUSY, DONE}; default localparams XLEN_D=32, NTRD_D=8, NREG_D=32.
- Sub-module exe_mul_iter: FSM, counter, and shift-add datapath. Interface: start, flush, hold, a, b, is_high → busy, done, result.
- Forwarding, the ALU and the pipeline register live in exe_mt.

Test Plan:
- Forward MEM beats WB: trd=3, MEM writes r5=0x10, WB writes r5=0x20, ADD r5+r0 → alu_out_mem=0x10.
- Load-use and r0 handling: MEM load to r7, same thread, EXE reads r7 → stall_exe=1 and bubble in MEM. A different thread, or rd=0, gives no stall.
- MUL latency: A=-3, B=7, op 8 at cycle 0 → stall_exe high cycles 0..32, alu_out_mem=0xFFFFFFEB after edge 34.
- MULH (macro on): A=0x80000000, B=2 → alu_out_mem=0xFFFFFFFF. Macro off: op 9 → 0 and no stall.
- flush_exe in BUSY cycle 10 → FSM IDLE, wr_en_mem stays 0. rst asserted in BUSY gives the same result.
- Overflow: ADD 0x7FFFFFFF+1 → of_exe=1; SUB 0x80000000-1 → of_exe=1; AND → of_exe=0.
